cnn_loader: RTL

Avalon-MM initiator that drives the CNN accelerator peripheral's slave port from the HPS side of the fabric. It accepts load/readback commands, streams image and weight bytes into the peripheral's per-region write ports, and reads result bytes back out of the output region into a byte stream. All bus traffic obeys `avm_waitrequest` and a fixed read latency.

---
 rtl/cnn_loader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cnn_loader.sv
// Avalon-MM initiator feeding the CNN peripheral: byte loads into region ports, byte readback to a stream.
// Loads take 2 cycles/byte at best; readback takes 1+READ_LATENCY+1 cycles/byte; all strobes hold under waitrequest.
module cnn_loader #(
  parameter int ADDR_W       = 19,
  parameter int LEN_W        = 19,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [2:0]        cmd_region,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic              avm_read,
  output logic [7:0]        avm_writedata,
  input  logic [7:0]        avm_readdata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, WR_FETCH, WR_BUS, RD_ISSUE, RD_WAIT, RD_OUT, FINISH
  } state_t;

  state_t            state;
  logic [2:0]        region;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  cnt_nxt;
  logic [2:0]        lat_cnt;
  logic              last;

  assign cnt_nxt = cnt + LEN_W'(1);
  assign last    = (cnt_nxt == len);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      region         <= '0;
      base           <= '0;
      len            <= '0;
      cnt            <= '0;
      lat_cnt        <= '0;
      cmd_ready      <= 1'b0;
      s_ready        <= 1'b0;
      m_data         <= '0;
      m_valid        <= 1'b0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_read       <= 1'b0;
      avm_writedata  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            region <= cmd_region;
            base   <= cmd_base;
            len    <= cmd_len;
            cnt    <= '0;
            if (cmd_len == '0) begin
              state     <= FINISH;
              done      <= 1'b1;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
            end else if (!cmd_op && (cmd_region > 3'd4)) begin
              // rejected load: stay ready so the next command can follow at once
              err <= 1'b1;
            end else if (!cmd_op) begin
              state     <= WR_FETCH;
              s_ready   <= 1'b1;
              busy      <= 1'b1;
              cmd_ready <= 1'b0;
            end else begin
              state          <= RD_ISSUE;
              avm_chipselect <= 1'b1;
              avm_read       <= 1'b1;
              avm_address    <= cmd_base;
              busy           <= 1'b1;
              cmd_ready      <= 1'b0;
            end
          end
        end
        WR_FETCH: begin
          if (s_valid) begin
            avm_writedata  <= s_data;
            s_ready        <= 1'b0;
            avm_chipselect <= 1'b1;
            avm_write      <= 1'b1;
            avm_address    <= ADDR_W'(region);
            state          <= WR_BUS;
          end
        end
        WR_BUS: begin
          if (!avm_waitrequest) begin
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            cnt            <= cnt_nxt;
            if (last) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state   <= WR_FETCH;
              s_ready <= 1'b1;
            end
          end
        end
        RD_ISSUE: begin
          if (!avm_waitrequest) begin
            avm_chipselect <= 1'b0;
            avm_read       <= 1'b0;
            lat_cnt        <= 3'd1;
            state          <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // lat_cnt counts cycles since the accepted read; data is valid when it reaches the latency
          if (lat_cnt == 3'(READ_LATENCY)) begin
            m_data  <= avm_readdata;
            m_valid <= 1'b1;
            state   <= RD_OUT;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RD_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            cnt     <= cnt_nxt;
            if (last) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state          <= RD_ISSUE;
              avm_chipselect <= 1'b1;
              avm_read       <= 1'b1;
              avm_address    <= base + ADDR_W'(cnt_nxt);
            end
          end
        end
        FINISH: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
